// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word fetches, tags them with their PC,
// and buffers in-order responses for Decode, with redirect flush/drop.
module fetch_queue #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   input  logic                  stall_d,
   output logic                  mem_req,
   output logic [DATA_WIDTH-1:0] mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instr_out,
   output logic [DATA_WIDTH-1:0] pc_out,
   output logic [DATA_WIDTH-1:0] pcplus4_out
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   typedef logic [DATA_WIDTH-1:0] word_t;

   word_t fetchPc;
   word_t instrMem [DEPTH];
   word_t pcMem [DEPTH];
   word_t tagMem [DEPTH];

   logic [PW-1:0] headPtr;
   logic [PW-1:0] tailPtr;
   logic [PW-1:0] tagWrPtr;
   logic [PW-1:0] tagRdPtr;

   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] dropCnt;
   logic [CW:0]   credit;

   logic accept;
   logic rspValid;
   logic rspKeep;
   logic pop;

   // Outstanding includes to-be-dropped requests, so every live
   // response is guaranteed a free queue slot.
   assign credit = {1'b0, count} + {1'b0, outstanding};

   assign mem_req = rst && !redirect_valid
                 && (credit < DEPTH_C);
   assign mem_addr = fetchPc;
   assign accept = mem_req && mem_gnt;

   assign rspValid = mem_rvalid && (outstanding != '0);
   assign rspKeep = rspValid && !redirect_valid
                 && (dropCnt == '0);

   assign instr_valid = rst && (count != '0);
   assign pop = instr_valid && !stall_d && !redirect_valid;

   assign instr_out = instrMem[headPtr];
   assign pc_out = pcMem[headPtr];
   assign pcplus4_out = pcMem[headPtr] + DATA_WIDTH'(4);

   // Control state: fetch PC, pointers, occupancy and drop bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetchPc <= RESET_PC;
         headPtr <= '0;
         tailPtr <= '0;
         tagWrPtr <= '0;
         tagRdPtr <= '0;
         count <= '0;
         outstanding <= '0;
         dropCnt <= '0;
      end else begin
         if (accept) tagWrPtr <= tagWrPtr + PW'(1);
         if (rspValid) tagRdPtr <= tagRdPtr + PW'(1);
         outstanding <= outstanding + CW'(accept)
                      - CW'(rspValid);
         if (redirect_valid) begin
            fetchPc <= redirect_pc;
            dropCnt <= outstanding - CW'(rspValid);
            count <= '0;
            headPtr <= '0;
            tailPtr <= '0;
         end else begin
            if (accept) fetchPc <= fetchPc + DATA_WIDTH'(4);
            if (rspValid && (dropCnt != '0))
               dropCnt <= dropCnt - CW'(1);
            if (rspKeep) tailPtr <= tailPtr + PW'(1);
            if (pop) headPtr <= headPtr + PW'(1);
            count <= count + CW'(rspKeep) - CW'(pop);
         end
      end
   end

   // Storage: PC tags on grant, instruction/PC pairs on live response.
   always_ff @(posedge clk) begin
      if (accept) tagMem[tagWrPtr] <= fetchPc;
      if (rspKeep) begin
         instrMem[tailPtr] <= mem_rdata;
         pcMem[tailPtr] <= tagMem[tagRdPtr];
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: memory model with response
// scoreboard, plus per-scenario directed checks.
module tb_fetch_queue;

   localparam int DW = 32;
   localparam int DEPTH = 4;
   localparam logic [31:0] RPC = 32'h0;

   logic clk = 1'b0;
   logic rst;
   logic redirect_valid;
   logic [31:0] redirect_pc;
   logic stall_d;
   logic mem_req;
   logic [31:0] mem_addr;
   logic mem_gnt;
   logic mem_rvalid;
   logic [31:0] mem_rdata;
   logic instr_valid;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic [31:0] pcplus4_out;

   fetch_queue #(
      .DATA_WIDTH(DW),
      .DEPTH(DEPTH),
      .RESET_PC(RPC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .stall_d(stall_d),
      .mem_req(mem_req),
      .mem_addr(mem_addr),
      .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata),
      .instr_valid(instr_valid),
      .instr_out(instr_out),
      .pc_out(pc_out),
      .pcplus4_out(pcplus4_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      int ep;
   } pend_t;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int epoch = 0;
   int drops = 0;
   int firstValidCyc = -1;

   pend_t pend[$];
   logic [31:0] expQ[$];
   logic [31:0] grantAddr[$];
   int grantCyc[$];
   logic [31:0] popPc[$];
   logic [31:0] popP4[$];

   logic [31:0] expPc;
   bit rvLive = 1'b0;
   int rvEp = 0;
   logic [31:0] rvPc;
   bit rspHold = 1'b0;
   bit strayRv = 1'b0;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic clearModel();
      pend.delete();
      expQ.delete();
      rvLive = 1'b0;
      mem_rvalid = 1'b0;
      expPc = RPC;
      epoch++;
   endtask

   task automatic clearLogs();
      grantAddr.delete();
      grantCyc.delete();
      popPc.delete();
      popP4.delete();
      firstValidCyc = -1;
      drops = 0;
   endtask

   // One clock cycle: scoreboard checks before the edge, memory after.
   task automatic tick();
      logic expReq;
      logic expVal;
      logic [31:0] e;
      pend_t p;
      bit acc;
      int outst;
      #1;
      outst = pend.size() + (rvLive ? 1 : 0);
      expReq = rst && !redirect_valid
            && ((expQ.size() + outst) < DEPTH);
      expVal = (expQ.size() != 0);
      tests++;
      if (mem_req !== expReq) begin
         fails++;
         $display("FAIL mem_req cyc %0d: got %b, expected %b",
                  cyc, mem_req, expReq);
      end
      tests++;
      if (mem_addr !== expPc) begin
         fails++;
         $display("FAIL mem_addr cyc %0d: got %h, expected %h",
                  cyc, mem_addr, expPc);
      end
      tests++;
      if (instr_valid !== expVal) begin
         fails++;
         $display("FAIL instr_valid cyc %0d: got %b, expected %b",
                  cyc, instr_valid, expVal);
      end
      if (instr_valid === 1'b1 && firstValidCyc < 0)
         firstValidCyc = cyc;
      acc = (mem_req === 1'b1) && (mem_gnt === 1'b1);
      if (rst === 1'b1) begin
         if (redirect_valid) begin
            if (rvLive) drops++;
            expQ.delete();
            epoch++;
            expPc = redirect_pc;
         end else begin
            if (instr_valid === 1'b1 && !stall_d) begin
               tests++;
               if (expQ.size() == 0) begin
                  fails++;
                  $display("FAIL pop cyc %0d: got pc %h, expected none",
                           cyc, pc_out);
               end else begin
                  e = expQ.pop_front();
                  if (pc_out !== e || instr_out !== memWord(e)
                      || pcplus4_out !== e + 32'd4) begin
                     fails++;
                     $display("FAIL head cyc %0d: got %h/%h/%h, expected %h/%h/%h",
                              cyc, pc_out, instr_out, pcplus4_out,
                              e, memWord(e), e + 32'd4);
                  end
               end
               popPc.push_back(pc_out);
               popP4.push_back(pcplus4_out);
            end
            if (rvLive) begin
               if (rvEp == epoch) expQ.push_back(rvPc);
               else drops++;
            end
            if (acc) begin
               p.pc = expPc;
               p.ep = epoch;
               pend.push_back(p);
               grantAddr.push_back(mem_addr);
               grantCyc.push_back(cyc);
               expPc = expPc + 32'd4;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      mem_rvalid = 1'b0;
      rvLive = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      if (!rspHold && pend.size() > 0) begin
         p = pend.pop_front();
         mem_rvalid = 1'b1;
         mem_rdata = memWord(p.pc);
         rvLive = 1'b1;
         rvEp = p.ep;
         rvPc = p.pc;
      end else if (strayRv) begin
         mem_rvalid = 1'b1;
      end
   endtask

   task automatic doReset();
      rst = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      stall_d = 1'b0;
      mem_gnt = 1'b0;
      rspHold = 1'b0;
      strayRv = 1'b0;
      clearModel();
      tick();
      tick();
      rst = 1'b1;
      clearLogs();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      stall_d = 1'b0;
      mem_gnt = 1'b0;
      mem_rdata = '0;
      clearModel();
      #1;
      tests++;
      if (mem_req !== 1'b0) begin
         fails++;
         $display("FAIL rst_mem_req: got %b, expected 0", mem_req);
      end
      tests++;
      if (instr_valid !== 1'b0) begin
         fails++;
         $display("FAIL rst_valid: got %b, expected 0", instr_valid);
      end
      tests++;
      if (mem_addr !== RPC) begin
         fails++;
         $display("FAIL rst_addr: got %h, expected %h", mem_addr, RPC);
      end
      tick();
      tick();
      rst = 1'b1;
      #1;
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== RPC) begin
         fails++;
         $display("FAIL first_req: got %b/%h, expected 1/%h",
                  mem_req, mem_addr, RPC);
      end
      clearLogs();
   endtask

   task automatic test_zero_wait();
      doReset();
      mem_gnt = 1'b1;
      repeat (12) tick();
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (i >= grantAddr.size() || grantAddr[i] !== 32'(4 * i)) begin
            fails++;
            $display("FAIL zw_addr[%0d]: got %h, expected %h", i,
                     (i < grantAddr.size()) ? grantAddr[i] : 32'hX,
                     32'(4 * i));
         end
      end
      tests++;
      if (grantCyc.size() == 0 || firstValidCyc - grantCyc[0] != 2) begin
         fails++;
         $display("FAIL zw_latency: got %0d, expected 2",
                  (grantCyc.size() == 0) ? -1 : firstValidCyc - grantCyc[0]);
      end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (i >= popPc.size() || popPc[i] !== 32'(4 * i)
             || popP4[i] !== 32'(4 * i + 4)) begin
            fails++;
            $display("FAIL zw_pop[%0d]: got %h/%h, expected %h/%h", i,
                     (i < popPc.size()) ? popPc[i] : 32'hX,
                     (i < popP4.size()) ? popP4[i] : 32'hX,
                     32'(4 * i), 32'(4 * i + 4));
         end
      end
      mem_gnt = 1'b0;
   endtask

   task automatic test_stall();
      doReset();
      stall_d = 1'b1;
      mem_gnt = 1'b1;
      repeat (10) tick();
      tests++;
      if (grantAddr.size() != 4) begin
         fails++;
         $display("FAIL stall_grants: got %0d, expected 4",
                  grantAddr.size());
      end
      tests++;
      if (mem_req !== 1'b0) begin
         fails++;
         $display("FAIL stall_req: got %b, expected 0", mem_req);
      end
      tests++;
      if (instr_valid !== 1'b1 || pc_out !== 32'h0) begin
         fails++;
         $display("FAIL stall_head: got %b/%h, expected 1/0",
                  instr_valid, pc_out);
      end
      stall_d = 1'b0;
      repeat (8) tick();
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (i >= popPc.size() || popPc[i] !== 32'(4 * i)) begin
            fails++;
            $display("FAIL stall_pop[%0d]: got %h, expected %h", i,
                     (i < popPc.size()) ? popPc[i] : 32'hX, 32'(4 * i));
         end
      end
      tests++;
      if (grantAddr.size() < 5 || grantAddr[4] !== 32'd16) begin
         fails++;
         $display("FAIL stall_resume: got %h, expected 10",
                  (grantAddr.size() < 5) ? 32'hX : grantAddr[4]);
      end
      mem_gnt = 1'b0;
   endtask

   task automatic test_redirect();
      doReset();
      mem_gnt = 1'b1;
      rspHold = 1'b1;
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      #1;
      tests++;
      if (mem_req !== 1'b0) begin
         fails++;
         $display("FAIL redir_req: got %b, expected 0", mem_req);
      end
      tick();
      redirect_valid = 1'b0;
      rspHold = 1'b0;
      #1;
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
         fails++;
         $display("FAIL redir_addr: got %b/%h, expected 1/100",
                  mem_req, mem_addr);
      end
      repeat (10) tick();
      tests++;
      if (drops != 2) begin
         fails++;
         $display("FAIL redir_drops: got %0d, expected 2", drops);
      end
      tests++;
      if (popPc.size() == 0 || popPc[0] !== 32'h100) begin
         fails++;
         $display("FAIL redir_first: got %h, expected 100",
                  (popPc.size() == 0) ? 32'hX : popPc[0]);
      end
      mem_gnt = 1'b0;
   endtask

   task automatic test_back_to_back();
      doReset();
      mem_gnt = 1'b1;
      rspHold = 1'b1;
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      rspHold = 1'b0;
      tick();
      redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      repeat (10) tick();
      tests++;
      if (popPc.size() == 0 || popPc[0] !== 32'h200) begin
         fails++;
         $display("FAIL b2b_first: got %h, expected 200",
                  (popPc.size() == 0) ? 32'hX : popPc[0]);
      end
      foreach (popPc[i]) begin
         tests++;
         if (popPc[i] < 32'h200) begin
            fails++;
            $display("FAIL b2b_stale[%0d]: got %h, expected >= 200",
                     i, popPc[i]);
         end
      end
      tests++;
      if (drops != 2) begin
         fails++;
         $display("FAIL b2b_drops: got %0d, expected 2", drops);
      end
      mem_gnt = 1'b0;
   endtask

   task automatic test_grant_withheld();
      doReset();
      mem_gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         tests++;
         if (mem_req !== 1'b1 || mem_addr !== RPC) begin
            fails++;
            $display("FAIL hold[%0d]: got %b/%h, expected 1/%h",
                     i, mem_req, mem_addr, RPC);
         end
         tick();
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      #1;
      tests++;
      if (mem_addr !== RPC + 32'd4 || grantAddr.size() != 1) begin
         fails++;
         $display("FAIL hold_adv: got %h/%0d, expected %h/1",
                  mem_addr, grantAddr.size(), RPC + 32'd4);
      end
      repeat (4) tick();
   endtask

   task automatic test_async_reset();
      int n;
      doReset();
      stall_d = 1'b1;
      mem_gnt = 1'b1;
      n = 0;
      while (expQ.size() < 3 && n < 20) begin
         tick();
         n++;
      end
      tests++;
      if (expQ.size() != 3) begin
         fails++;
         $display("FAIL ar_fill: got %0d entries, expected 3",
                  expQ.size());
      end
      #1;
      rst = 1'b0;
      #1;
      tests++;
      if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
         fails++;
         $display("FAIL ar_immediate: got %b/%b, expected 0/0",
                  instr_valid, mem_req);
      end
      clearModel();
      mem_gnt = 1'b0;
      stall_d = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      strayRv = 1'b1;
      repeat (3) tick();
      tests++;
      if (instr_valid !== 1'b0) begin
         fails++;
         $display("FAIL ar_stray: got %b, expected 0", instr_valid);
      end
      strayRv = 1'b0;
      mem_gnt = 1'b1;
      clearLogs();
      repeat (6) tick();
      tests++;
      if (grantAddr.size() == 0 || grantAddr[0] !== RPC) begin
         fails++;
         $display("FAIL ar_addr: got %h, expected %h",
                  (grantAddr.size() == 0) ? 32'hX : grantAddr[0], RPC);
      end
      tests++;
      if (popPc.size() == 0 || popPc[0] !== RPC) begin
         fails++;
         $display("FAIL ar_first: got %h, expected %h",
                  (popPc.size() == 0) ? 32'hX : popPc[0], RPC);
      end
      mem_gnt = 1'b0;
   endtask

   initial begin
      mem_rvalid = 1'b0;
      test_reset();
      test_zero_wait();
      test_stall();
      test_redirect();
      test_back_to_back();
      test_grant_withheld();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
